// File: rtl/sad_accum_rtl.sv
// Streaming sum-of-absolute-differences over fixed-size blocks with valid/ready handshakes.
// Define SAD_ACCUM_MAX_EN to add a max_diff output tracking the largest |in0-in1| per block.
module sad_accum_rtl #(
    parameter int nbits  = 4,
    parameter int nelems = 8,
    localparam int swidth = nbits + $clog2(nelems)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_val,
    output logic              in_rdy,
    input  logic [nbits-1:0]  in0,
    input  logic [nbits-1:0]  in1,
    output logic              out_val,
    input  logic              out_rdy,
    output logic [swidth-1:0] sum
`ifdef SAD_ACCUM_MAX_EN
    ,
    output logic [nbits-1:0]  max_diff
`endif
);

    localparam int cwidth = $clog2(nelems + 1);
    localparam logic [cwidth-1:0] last = cwidth'(nelems - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t             state, state_nx;
    logic [swidth-1:0]  acc, acc_nx;
    logic [cwidth-1:0]  cnt, cnt_nx;
    logic [nbits-1:0]   diff;
    logic               in_xfer;
    logic               out_xfer;

    // Subtract the smaller from the larger so the result never wraps.
    assign diff     = (in0 >= in1) ? (in0 - in1) : (in1 - in0);
    assign in_rdy   = reset && (state != DONE);
    assign out_val  = (state == DONE);
    assign in_xfer  = in_val && in_rdy;
    assign out_xfer = out_val && out_rdy;
    assign sum      = acc;

`ifdef SAD_ACCUM_MAX_EN
    logic [nbits-1:0] mx, mx_nx;
    assign max_diff = mx;
`endif

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
`ifdef SAD_ACCUM_MAX_EN
        mx_nx    = mx;
`endif
        unique case (state)
            IDLE, ACCUM: begin
                if (in_xfer) begin
                    acc_nx   = acc + swidth'(diff);
                    cnt_nx   = cnt + cwidth'(1);
                    state_nx = (cnt == last) ? DONE : ACCUM;
`ifdef SAD_ACCUM_MAX_EN
                    if (diff > mx) mx_nx = diff;
`endif
                end
            end
            DONE: begin
                if (out_xfer) begin
                    state_nx = IDLE;
                    acc_nx   = '0;
                    cnt_nx   = '0;
`ifdef SAD_ACCUM_MAX_EN
                    mx_nx    = '0;
`endif
                end
            end
            default: begin
                state_nx = IDLE;
                acc_nx   = '0;
                cnt_nx   = '0;
`ifdef SAD_ACCUM_MAX_EN
                mx_nx    = '0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
`ifdef SAD_ACCUM_MAX_EN
            mx    <= '0;
`endif
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
`ifdef SAD_ACCUM_MAX_EN
            mx    <= mx_nx;
`endif
        end
    end

endmodule

// File: tb/tb_sad_accum_rtl.sv
// Directed and randomized self-checking bench for sad_accum_rtl (nbits=4, nelems=4).
module tb_sad_accum_rtl;

    localparam int NB = 4;
    localparam int NE = 4;
    localparam int SW = NB + $clog2(NE);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_val;
    logic          in_rdy;
    logic [NB-1:0] in0;
    logic [NB-1:0] in1;
    logic          out_val;
    logic          out_rdy;
    logic [SW-1:0] sum;
`ifdef SAD_ACCUM_MAX_EN
    logic [NB-1:0] max_diff;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sad_accum_rtl #(.nbits(NB), .nelems(NE)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in0     (in0),
        .in1     (in1),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .sum     (sum)
`ifdef SAD_ACCUM_MAX_EN
        ,
        .max_diff(max_diff)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int a, input int b);
        logic [31:0] av;
        logic [31:0] bv;
        av = a;
        bv = b;
        in_val = 1'b1;
        in0 = av[NB-1:0];
        in1 = bv[NB-1:0];
        tick();
        in_val = 1'b0;
    endtask

    task automatic done_chk(input string tag, input int es, input int em);
        chk({tag, "_outval"}, 32'(out_val), 1);
        chk({tag, "_sum"}, 32'(sum), es);
        chk({tag, "_inrdy"}, 32'(in_rdy), 0);
`ifdef SAD_ACCUM_MAX_EN
        chk({tag, "_max"}, 32'(max_diff), em);
`else
        if (em < 0) $display("negative max %0d", em);
`endif
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_outval"}, 32'(out_val), 0);
        chk({tag, "_sum"}, 32'(sum), 0);
        chk({tag, "_inrdy"}, 32'(in_rdy), 1);
`ifdef SAD_ACCUM_MAX_EN
        chk({tag, "_max"}, 32'(max_diff), 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        in_val = 1'b0;
        in0 = '0;
        in1 = '0;
        out_rdy = 1'b0;
        tick();
        tick();
        chk("rst_sum", 32'(sum), 0);
        chk("rst_outval", 32'(out_val), 0);
        chk("rst_inrdy", 32'(in_rdy), 0);
        reset = 1'b1;
        #1;
        idle_chk("post_rst");

        // all zero operands
        out_rdy = 1'b1;
        repeat (NE) xfer(0, 0);
        done_chk("zero", 0, 0);
        tick();
        idle_chk("zero_idle");

        // full-scale differences in both directions
        xfer(15, 0);
        xfer(0, 15);
        xfer(15, 0);
        xfer(0, 15);
        done_chk("full", 60, 15);
        tick();
        idle_chk("full_idle");

        // backpressure with an ignored input during DONE
        out_rdy = 1'b0;
        xfer(3, 5);
        xfer(9, 2);
        xfer(4, 4);
        xfer(1, 8);
        in_val = 1'b1;
        in0 = 4'd15;
        in1 = 4'd0;
        for (int i = 0; i < 3; i++) begin
            done_chk("hold", 16, 7);
            if (i < 2) tick();
        end
        in_val = 1'b0;
        out_rdy = 1'b1;
        tick();
        idle_chk("hold_idle");

        // gaps in in_val mid-block
        xfer(7, 1);
        xfer(2, 6);
        tick();
        tick();
        chk("gap_sum", 32'(sum), 10);
        chk("gap_outval", 32'(out_val), 0);
        xfer(5, 5);
        xfer(0, 3);
        done_chk("gap", 13, 6);
        tick();
        idle_chk("gap_idle");

        // reset mid-block discards the partial result
        xfer(15, 0);
        xfer(15, 0);
        chk("mid_outval", 32'(out_val), 0);
        reset = 1'b0;
        #1;
        chk("mid_rst_inrdy", 32'(in_rdy), 0);
        tick();
        chk("mid_rst_sum", 32'(sum), 0);
        chk("mid_rst_outval", 32'(out_val), 0);
        reset = 1'b1;
        repeat (NE) xfer(1, 0);
        done_chk("after_rst", 4, 1);
        tick();
        idle_chk("after_rst_idle");

        // random blocks with random consumer stalls
        for (int b = 0; b < 50; b++) begin
            int es;
            int em;
            int a;
            int c;
            int d;
            es = 0;
            em = 0;
            out_rdy = 1'($urandom_range(0, 1));
            for (int k = 0; k < NE; k++) begin
                a = int'($urandom_range(0, 15));
                c = int'($urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) tick();
                d = (a > c) ? a - c : c - a;
                es += d;
                if (d > em) em = d;
                xfer(a, c);
            end
            for (int w = 0; w < 8; w++) begin
                out_rdy = (w == 7) ? 1'b1 : 1'($urandom_range(0, 1));
                done_chk("rnd", es, em);
                tick();
                if (out_rdy) break;
            end
            out_rdy = 1'b0;
            idle_chk("rnd_idle");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sad_accum_rtl.md
SAD_ACCUM_RTL -- requirements
Module: sad_accum_rtl

Interface
REQ-001 Parameter nbits, default 4: element width in bits, legal range 1..32.
REQ-002 Parameter nelems, default 8: element pairs per block, legal range 2..256.
REQ-003 Derived width swidth = nbits + $clog2(nelems): sum width, wide enough that no overflow is possible.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous active-low reset; 0 at a rising clk edge resets the block.
REQ-006 Port in_val, input, 1: producer presents a valid element pair.
REQ-007 Port in_rdy, output, 1: block can accept an element pair.
REQ-008 Port in0, input, nbits: unsigned operand A.
REQ-009 Port in1, input, nbits: unsigned operand B.
REQ-010 Port out_val, output, 1: sum holds a completed block result.
REQ-011 Port out_rdy, input, 1: consumer accepts the result.
REQ-012 Port sum, output, swidth: sum of |in0-in1| over the block.

Function
REQ-013 An input transfer SHALL occur on a rising edge where in_val=1 and in_rdy=1; no other input is consumed.
REQ-014 An output transfer SHALL occur on a rising edge where out_val=1 and out_rdy=1.
REQ-015 FSM states SHALL be IDLE (cnt=0), ACCUM (0<cnt<nelems) and DONE (result held).
REQ-016 Transitions SHALL be: IDLE->ACCUM on input transfer; ACCUM->DONE on the transfer that makes cnt=nelems; DONE->IDLE on output transfer; otherwise hold.
REQ-017 in_rdy SHALL be 1 in IDLE and ACCUM, and 0 in DONE.
REQ-018 out_val SHALL be 1 only in DONE.
REQ-019 On each input transfer, acc SHALL become acc + |in0-in1| (unsigned, zero-extended to swidth) and cnt SHALL increment by 1.
REQ-020 |in0-in1| SHALL be exact for all operands, including 0 vs 2^nbits-1.
REQ-021 sum SHALL be driven directly from acc; latency from the last input transfer to out_val=1 is one cycle.
REQ-022 sum and out_val SHALL stay stable while out_val=1 and out_rdy=0.
REQ-023 On DONE->IDLE, acc and cnt SHALL clear to 0 on the same edge.
REQ-024 in_val=1 in DONE SHALL be ignored; nothing is accumulated or dropped from the next block.
REQ-025 Gaps in in_val within a block SHALL not affect the result.
REQ-026 Peak throughput SHALL be one block per nelems+1 cycles.

Reset
REQ-027 While reset=0 at a rising edge, the block SHALL enter IDLE with acc=0, cnt=0, out_val=0 and sum=0.
REQ-028 in_rdy SHALL be 0 in any cycle where reset=0.
REQ-029 Reset mid-block or in DONE SHALL discard the partial or held result; the first block after reset starts from cnt=0.

Configuration
REQ-030 Macro SAD_ACCUM_MAX_EN, when defined, SHALL add output port max_diff [nbits]: the largest |in0-in1| seen in the current block.
REQ-031 With SAD_ACCUM_MAX_EN defined, max_diff SHALL update on each input transfer, be valid and stable with sum, clear to 0 on DONE->IDLE, and reset to 0.
REQ-032 Without SAD_ACCUM_MAX_EN, the max_diff port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification (nbits=4, nelems=4)
REQ-033 Scenario: pairs (0,0)x4, out_rdy=1 -> out_val=1 one cycle after the 4th transfer with sum=0 (max_diff=0); next cycle IDLE with in_rdy=1.
REQ-034 Scenario: pairs (15,0),(0,15),(15,0),(0,15) -> sum=60, the full-scale bound with no overflow (max_diff=15).
REQ-035 Scenario: pairs (3,5),(9,2),(4,4),(1,8), out_rdy=0 for 3 cycles -> sum=16 held for those 3 cycles, in_rdy=0, in_val=1 with (15,0) ignored; after out_rdy=1 the next block starts from 0.
REQ-036 Scenario: pairs (7,1),(2,6), in_val=0 for 2 cycles, then (5,5),(0,3) -> sum=13 (max_diff=6).
REQ-037 Scenario: pairs (15,0),(15,0), reset=0 for 1 cycle, then pairs (1,0)x4 -> sum=4; the partial result 30 never appears on sum.
REQ-038 Scenario: random operands, 50 blocks, out_rdy randomly toggled -> each sum matches a reference model and no block is lost or duplicated.
